// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Each
// requester hands over (a, b, op) and later receives the ALU result. Only one
// operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Contention is resolved round-robin; after reset requester 0 wins first.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The sender holds valid (and data
// meaningful) until that edge; ready never depends on the same-cycle ready of
// the other side, and rsp_valid/rsp_result never change while waiting.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid[1:0]       per-requester operation valid
//   req_ready[1:0]       per-requester accept (combinational, IDLE only)
//   req{0,1}_a/_b/_op    operands and opcode from each requester
//   rsp_valid[1:0]       per-requester result valid (registered, one-hot)
//   rsp_ready[1:0]       per-requester result accept
//   rsp_result           shared result, meaningful where rsp_valid is set
//   alu_a/alu_b/alu_op   registered operands to the ALU
//   alu_result           combinational ALU result
//   busy                 high whenever the FSM is not in IDLE
//   done_cnt             completed responses, wraps 255 -> 0
//   dbg_state            current FSM state encoding (IDLE=0, EXEC=1, RESP=2)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int A_W   = 4,
    parameter int OP_W  = 2,
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [A_W-1:0]   req0_a,
    input  logic [A_W-1:0]   req1_a,
    input  logic [A_W-1:0]   req0_b,
    input  logic [A_W-1:0]   req1_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [OP_W-1:0]  req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic [A_W-1:0]   alu_a,
    output logic [A_W-1:0]   alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [RES_W-1:0] alu_result,
    output logic             busy,
    output logic [7:0]       done_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;   // requester served most recently
    logic   gsel;         // requester owning the operation in flight
    logic   grant;        // IDLE-cycle winner
    logic   req_fire;
    logic   rsp_fire;

    // A lone requester always wins; under contention the one not served
    // last wins, which gives strict alternation.
    always_comb begin
        grant = ~last_grant;
        if (req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    // Ready is offered only to the winner, only in IDLE, and never while the
    // block is held in reset.
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (state == IDLE)) begin
            req_ready[grant] = req_valid[grant];
        end
    end

    assign req_fire  = |req_ready;
    assign rsp_fire  = (state == RESP) && rsp_ready[gsel];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gsel       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            done_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        alu_a  <= grant ? req1_a  : req0_a;
                        alu_b  <= grant ? req1_b  : req0_b;
                        alu_op <= grant ? req1_op : req0_op;
                        gsel   <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle here.
                    rsp_result <= alu_result;
                    rsp_valid  <= gsel ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_valid  <= 2'b00;
                        last_grant <= gsel;
                        done_cnt   <= done_cnt + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. Provides a behavioural ALU (add/sub/and/or), a
// driver/monitor process that feeds queued operations and scores responses
// against an expected queue, and directed sequences for latency, contention,
// back-pressure, reset abort and counter wrap.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req1_a, req0_b, req1_b;
    logic [1:0] req0_op, req1_op;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic [7:0] done_cnt;
    logic [1:0] dbg_state;

    alu_arbiter #(.A_W(4), .OP_W(2), .RES_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req1_a     (req1_a),
        .req0_b     (req0_b),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy),
        .done_cnt   (done_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- reference ALU ----------------
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return {4'b0, a} + {4'b0, b};
            2'd1:    return {4'b0, a} - {4'b0, b};
            2'd2:    return {4'b0, a & b};
            default: return {4'b0, a | b};
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];     // {requester id, result}
    int         grant_q[$];   // requester id per accepted request
    logic [9:0] pend0_q[$];   // queued {a, b, op} for requester 0
    logic [9:0] pend1_q[$];
    int         sent0, sent1;
    logic       auto_drv;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Step to two time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int outstanding();
        return (pend0_q.size() - sent0) + (pend1_q.size() - sent1) + exp_q.size() + int'(busy);
    endfunction

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            tick();
            if (outstanding() == 0) break;
        end
        check("drain", 32'(outstanding()), 32'd0);
        auto_drv = 1'b0;
    endtask

    task automatic do_reset();
        auto_drv  = 1'b0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
    endtask

    task automatic push_op(input int who);
        logic [9:0] e;
        e = {4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
        if (who == 0) pend0_q.push_back(e);
        else          pend1_q.push_back(e);
    endtask

    // ---------------- monitor + queued driver ----------------
    initial begin
        logic [8:0] e;
        sent0 = 0;
        sent1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (req_valid[0] && req_ready[0]) begin
                    exp_q.push_back({1'b0, alu_model(req0_a, req0_b, req0_op)});
                    grant_q.push_back(0);
                    if (auto_drv) sent0++;
                end
                if (req_valid[1] && req_ready[1]) begin
                    exp_q.push_back({1'b1, alu_model(req1_a, req1_b, req1_op)});
                    grant_q.push_back(1);
                    if (auto_drv) sent1++;
                end
                if (busy) check("ready_while_busy", 32'(req_ready), 32'd0);
                if (rsp_valid != 2'b00) check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
                for (int i = 0; i < 2; i++) begin
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("rsp_id", 32'(i), 32'(e[8]));
                            check("rsp_result", 32'(rsp_result), 32'(e[7:0]));
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            if (auto_drv) begin
                if (sent0 < pend0_q.size()) begin
                    req_valid[0] = 1'b1;
                    {req0_a, req0_b, req0_op} = pend0_q[sent0];
                end else begin
                    req_valid[0] = 1'b0;
                end
                if (sent1 < pend1_q.size()) begin
                    req_valid[1] = 1'b1;
                    {req1_a, req1_b, req1_op} = pend1_q[sent1];
                end else begin
                    req_valid[1] = 1'b0;
                end
            end
        end
    end

    // ---------------- test sequences ----------------
    initial begin
        int base;
        n_checks  = 0;
        n_pass    = 0;
        auto_drv  = 1'b0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        // Single request: 3 + 5 from requester 0.
        do_reset();
        tick();
        req_valid = 2'b01; req0_a = 4'd3; req0_b = 4'd5; req0_op = 2'd0;
        rsp_ready = 2'b11;
        #1;
        check("single_ready_c0", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        check("single_alu_a_c1", 32'(alu_a), 32'd3);
        check("single_alu_b_c1", 32'(alu_b), 32'd5);
        check("single_alu_op_c1", 32'(alu_op), 32'd0);
        check("single_busy_c1", 32'(busy), 32'd1);
        check("single_rsp_valid_c1", 32'(rsp_valid), 32'd0);
        tick();
        check("single_rsp_valid_c2", 32'(rsp_valid), 32'b01);
        check("single_rsp_result_c2", 32'(rsp_result), 32'd8);
        check("single_busy_c2", 32'(busy), 32'd1);
        tick();
        check("single_busy_c3", 32'(busy), 32'd0);
        check("single_done_cnt", 32'(done_cnt), 32'd1);

        // Contention from reset: requester 0 first, then requester 1.
        do_reset();
        base = grant_q.size();
        pend0_q.push_back({4'd2, 4'd1, 2'd1});
        pend1_q.push_back({4'd12, 4'd10, 2'd2});
        rsp_ready = 2'b11;
        auto_drv  = 1'b1;
        wait_drain(40);
        check("cont_grant_cnt", 32'(grant_q.size() - base), 32'd2);
        if (grant_q.size() - base == 2) begin
            check("cont_grant0", 32'(grant_q[base]), 32'd0);
            check("cont_grant1", 32'(grant_q[base + 1]), 32'd1);
        end

        // Sustained contention: strict alternation over six requests.
        do_reset();
        base = grant_q.size();
        for (int k = 0; k < 3; k++) begin
            push_op(0);
            push_op(1);
        end
        rsp_ready = 2'b11;
        auto_drv  = 1'b1;
        wait_drain(80);
        check("sust_grant_cnt", 32'(grant_q.size() - base), 32'd6);
        if (grant_q.size() - base == 6) begin
            for (int k = 0; k < 6; k++) check("sust_grant", 32'(grant_q[base + k]), 32'(k % 2));
        end
        check("sust_done_cnt", 32'(done_cnt), 32'd6);

        // Response back-pressure on requester 1.
        do_reset();
        tick();
        req_valid = 2'b10; req1_a = 4'd7; req1_b = 4'd9; req1_op = 2'd3;
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b01; req0_a = 4'd1; req0_b = 4'd1; req0_op = 2'd0;
        rsp_ready = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'b10);
            check("bp_rsp_result", 32'(rsp_result), 32'd15);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        check("bp_req_ready_last", 32'(req_ready), 32'd0);
        tick();
        check("bp_grant_after", 32'(req_ready), 32'b01);
        check("bp_busy_after", 32'(busy), 32'd0);
        tick();
        req_valid = 2'b00;
        check("bp_alu_a_req0", 32'(alu_a), 32'd1);
        wait_drain(10);
        check("bp_done_cnt", 32'(done_cnt), 32'd2);

        // Reset during EXEC aborts the operation asynchronously.
        tick();
        req_valid = 2'b01; req0_a = 4'd5; req0_b = 4'd4; req0_op = 2'd2;
        tick();
        req_valid = 2'b00;
        check("abort_busy_exec", 32'(busy), 32'd1);
        check("abort_alu_a_exec", 32'(alu_a), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_alu_a", 32'(alu_a), 32'd0);
        check("abort_alu_b", 32'(alu_b), 32'd0);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        base = grant_q.size();
        push_op(0);
        push_op(1);
        auto_drv = 1'b1;
        wait_drain(40);
        check("abort_grant_cnt", 32'(grant_q.size() - base), 32'd2);
        if (grant_q.size() - base == 2) begin
            check("abort_first_grant", 32'(grant_q[base]), 32'd0);
            check("abort_second_grant", 32'(grant_q[base + 1]), 32'd1);
        end
        check("abort_done_after", 32'(done_cnt), 32'd2);

        // Counter wrap after 256 completions.
        do_reset();
        rsp_ready = 2'b11;
        for (int k = 0; k < 255; k++) push_op(0);
        auto_drv = 1'b1;
        wait_drain(255 * 3 + 40);
        check("wrap_done_255", 32'(done_cnt), 32'd255);
        push_op(0);
        auto_drv = 1'b1;
        wait_drain(20);
        check("wrap_done_0", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "time limit");
    end

endmodule
